cordic_vectoring_iter: RTL

Iterative circular-mode CORDIC in vectoring mode: converts a signed (x, y) sample to magnitude and phase, the inverse of the rotation-mode steps used on the transmit path. It sits at the front of the FM receive/demodulation chain, feeding phase to the discriminator. A single shared datapath runs ITERATIONS micro-rotations per sample under a small FSM with a strobe/ready handshake. Phase uses the codebase angle format: full circle = 2^ZWIDTH, π ↔ 2^(ZWIDTH-1).

---
 rtl/cordic_vectoring_iter_if.sv | 16 +
 rtl/cordic_vectoring_iter.sv | 133 +++++++++++++
 2 files changed

// File: rtl/cordic_vectoring_iter_if.sv
// Sample/result handshake bundle for the iterative vectoring CORDIC.
interface cordic_vectoring_iter_if #(
    parameter int WIDTH  = 16,
    parameter int ZWIDTH = 24
);
    logic signed [WIDTH-1:0]  xi;
    logic signed [WIDTH-1:0]  yi;
    logic                     stb_in;
    logic                     ready;
    logic        [WIDTH:0]    mag;
    logic signed [ZWIDTH-1:0] phase;
    logic                     stb_out;

    modport master (output xi, yi, stb_in, input ready, mag, phase, stb_out);
    modport slave  (input xi, yi, stb_in, output ready, mag, phase, stb_out);
endinterface

// File: rtl/cordic_vectoring_iter.sv
// Iterative vectoring CORDIC: (xi, yi) -> gain-scaled magnitude and phase; result ITERATIONS+1 cycles after accept.
// No backpressure on the result; stb_in is only honoured while ready, otherwise dropped.
module cordic_vectoring_iter #(
    parameter int WIDTH      = 16,
    parameter int ZWIDTH     = 24,
    parameter int ITERATIONS = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    cordic_vectoring_iter_if.slave bus
);
    localparam int CW = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;
    localparam logic [CW-1:0] LAST = CW'(ITERATIONS - 1);

    // Elaboration-time atan(2^-i) scaled so that pi == 2^(ZWIDTH-1).
    function automatic logic signed [ZWIDTH-1:0] alpha_f(input int i);
        real t, p, s, a;
        if (i == 0) return {3'b001, {(ZWIDTH-3){1'b0}}};
        t = 1.0;
        for (int k = 0; k < i; k++) t = t / 2.0;
        s = 0.0;
        p = t;
        for (int k = 0; k < 40; k++) begin
            if (k % 2 == 0) s = s + p / real'(2 * k + 1);
            else            s = s - p / real'(2 * k + 1);
            p = p * t * t;
        end
        a = s / 3.14159265358979323846 * (2.0 ** (ZWIDTH - 1));
        return ZWIDTH'(longint'(a));
    endfunction

    logic signed [ZWIDTH-1:0] alpha_tab [ITERATIONS];
    for (genvar g = 0; g < ITERATIONS; g++) begin : g_alpha
        localparam logic signed [ZWIDTH-1:0] A = alpha_f(g);
        assign alpha_tab[g] = A;
    end

    typedef enum logic {IDLE, ITER} state_t;
    state_t state, state_nx;

    logic signed [WIDTH+1:0]  x, y, x_nx, y_nx, xe, ye;
    logic signed [ZWIDTH-1:0] z, z_nx, alpha_cur;
    logic        [CW-1:0]     cnt, cnt_nx;
    logic                     zero_flag, zero_nx;
    logic        [WIDTH:0]    mag_q, mag_nx;
    logic signed [ZWIDTH-1:0] phase_q, phase_nx;
    logic                     stb_q, stb_nx;

    // Two guard bits: one for the K gain, one so -2^(WIDTH-1) negates cleanly.
    assign xe        = {{2{bus.xi[WIDTH-1]}}, bus.xi};
    assign ye        = {{2{bus.yi[WIDTH-1]}}, bus.yi};
    assign alpha_cur = alpha_tab[cnt];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            x         <= '0;
            y         <= '0;
            z         <= '0;
            cnt       <= '0;
            zero_flag <= 1'b0;
            mag_q     <= '0;
            phase_q   <= '0;
            stb_q     <= 1'b0;
        end else begin
            state     <= state_nx;
            x         <= x_nx;
            y         <= y_nx;
            z         <= z_nx;
            cnt       <= cnt_nx;
            zero_flag <= zero_nx;
            mag_q     <= mag_nx;
            phase_q   <= phase_nx;
            stb_q     <= stb_nx;
        end
    end

    always_comb begin
        state_nx = state;
        x_nx     = x;
        y_nx     = y;
        z_nx     = z;
        cnt_nx   = cnt;
        zero_nx  = zero_flag;
        mag_nx   = mag_q;
        phase_nx = phase_q;
        stb_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.stb_in) begin
                    // Left half-plane is folded right by a pi rotation.
                    if (bus.xi[WIDTH-1]) begin
                        x_nx = -xe;
                        y_nx = -ye;
                        z_nx = {1'b1, {(ZWIDTH-1){1'b0}}};
                    end else begin
                        x_nx = xe;
                        y_nx = ye;
                        z_nx = '0;
                    end
                    zero_nx  = (bus.xi == '0) && (bus.yi == '0);
                    cnt_nx   = '0;
                    state_nx = ITER;
                end
            end
            ITER: begin
                if (!y[WIDTH+1]) begin
                    x_nx = x + (y >>> cnt);
                    y_nx = y - (x >>> cnt);
                    z_nx = z + alpha_cur;
                end else begin
                    x_nx = x - (y >>> cnt);
                    y_nx = y + (x >>> cnt);
                    z_nx = z - alpha_cur;
                end
                if (cnt == LAST) begin
                    mag_nx   = x_nx[WIDTH:0];
                    phase_nx = zero_flag ? '0 : z_nx;
                    stb_nx   = 1'b1;
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.ready   = (state == IDLE);
    assign bus.mag     = mag_q;
    assign bus.phase   = phase_q;
    assign bus.stb_out = stb_q;
endmodule
